// File: rtl/nx_rwreg_ia_pkg.sv
// Shared types for the multi-table indirect-access register array: op codes,
// status codes, FSM states and the base capability mask.
package nx_rwreg_ia_pkg;

  typedef enum logic [3:0] {
    OP_NOP      = 4'd0,
    OP_READ     = 4'd1,
    OP_WRITE    = 4'd2,
    OP_INIT     = 4'd3,
    OP_READ_CLR = 4'd4
  } op_e;

  typedef enum logic [2:0] {
    ST_OK        = 3'd0,
    ST_BUSY      = 3'd1,
    ST_ERR_ADDR  = 3'd2,
    ST_ERR_TABLE = 3'd3,
    ST_ERR_RO    = 3'd4,
    ST_ERR_OP    = 3'd5
  } stat_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_FILL = 2'd2
  } state_e;

  localparam logic [15:0] CAPABILITY_BASE = 16'h000F;
  localparam logic [15:0] CAPABILITY_CLR  = 16'h0010;

endpackage

// File: rtl/nx_rwreg_ia_bank.sv
// One software-writable table of N_ENTRIES x N_DATA_BITS flops. A write wins
// over a clear; both target waddr. Contents are exported flat, entry 0 in the LSBs.
module nx_rwreg_ia_bank #(
  parameter int N_ENTRIES   = 32,
  parameter int N_DATA_BITS = 64,
  localparam int AW         = $clog2(N_ENTRIES)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           we,
  input  logic [AW-1:0]                  waddr,
  input  logic [N_DATA_BITS-1:0]         wdat,
  input  logic                           clr,
  output logic [N_ENTRIES*N_DATA_BITS-1:0] rdata
);

  logic [N_DATA_BITS-1:0] mem [N_ENTRIES];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int e = 0; e < N_ENTRIES; e++) mem[e] <= '0;
    end else if (we) begin
      mem[waddr] <= wdat;
    end else if (clr) begin
      mem[waddr] <= '0;
    end
  end

  for (genvar e = 0; e < N_ENTRIES; e++) begin : g_rd
    assign rdata[e*N_DATA_BITS +: N_DATA_BITS] = mem[e];
  end

endmodule

// File: rtl/nx_rwreg_indirect_access_mc.sv
// Multi-table register array behind the CSR command/status/data protocol.
// Optional read-and-clear op (op 4) is enabled by defining NX_RWREG_IA_CLR_ON_RD_EN.
module nx_rwreg_indirect_access_mc
  import nx_rwreg_ia_pkg::*;
#(
  parameter int                         N_REG_ADDR_BITS = 11,
  parameter logic [N_REG_ADDR_BITS-1:0] CMND_ADDRESS    = 11'h40C,
  parameter logic [N_REG_ADDR_BITS-1:0] DATA_ADDRESS    = 11'h410,
  parameter int                         N_DATA_BITS     = 64,
  parameter int                         N_ENTRIES       = 32,
  parameter int                         N_TABLES        = 2,
  parameter logic [N_TABLES-1:0]        RW_MASK         = 2'b10,
  localparam int AW = $clog2(N_ENTRIES),
  localparam int TW = (N_TABLES > 1) ? $clog2(N_TABLES) : 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic [N_REG_ADDR_BITS-1:0]                reg_addr,
  input  logic                                      wr_stb,
  input  logic [N_DATA_BITS-1:0]                    wr_dat,
  input  logic [3:0]                                cmnd_op,
  input  logic [AW-1:0]                             cmnd_addr,
  input  logic [TW-1:0]                             cmnd_table_id,
  output logic [2:0]                                stat_code,
  output logic [AW-1:0]                             stat_addr,
  output logic [TW-1:0]                             stat_table_id,
  output logic [15:0]                               capability_lst,
  output logic [N_DATA_BITS-1:0]                    rd_dat,
  input  logic [N_TABLES*N_ENTRIES*N_DATA_BITS-1:0] mem_ro,
  output logic [N_TABLES*N_ENTRIES*N_DATA_BITS-1:0] mem_rw
);

  localparam int TBL_BITS = N_ENTRIES * N_DATA_BITS;

`ifdef NX_RWREG_IA_CLR_ON_RD_EN
  localparam logic CLR_EN = 1'b1;
  assign capability_lst = CAPABILITY_BASE | CAPABILITY_CLR;
`else
  localparam logic CLR_EN = 1'b0;
  assign capability_lst = CAPABILITY_BASE;
`endif

  state_e                 state;
  stat_e                  stat_q;
  stat_e                  cmd_err;
  logic [3:0]             op_q;
  logic [AW-1:0]          addr_q;
  logic [TW-1:0]          tid_q;
  logic [AW-1:0]          fill_cnt;
  logic [N_DATA_BITS-1:0] data_reg;
  logic [N_DATA_BITS-1:0] rd_entry;
  logic [31:0]            rd_base;
  logic                   op_legal;
  logic                   cmd_hit;
  logic                   rd_done;

  assign cmd_hit  = wr_stb && (reg_addr == CMND_ADDRESS) && (state == S_IDLE);
  assign op_legal = (cmnd_op <= 4'd3) || (CLR_EN && cmnd_op == OP_READ_CLR);
  assign rd_done  = (state == S_EXEC) && (op_q == OP_READ || op_q == OP_READ_CLR);

  // First failing check wins; INIT ignores the entry index entirely.
  always_comb begin
    cmd_err = ST_OK;
    if (!op_legal)
      cmd_err = ST_ERR_OP;
    else if (32'(cmnd_table_id) >= 32'(N_TABLES))
      cmd_err = ST_ERR_TABLE;
    else if (cmnd_op != OP_INIT && 32'(cmnd_addr) >= 32'(N_ENTRIES))
      cmd_err = ST_ERR_ADDR;
    else if (cmnd_op != OP_NOP && cmnd_op != OP_READ && !RW_MASK[cmnd_table_id])
      cmd_err = ST_ERR_RO;
  end

  always_comb begin
    rd_base  = (32'(tid_q) * 32'(N_ENTRIES) + 32'(addr_q)) * 32'(N_DATA_BITS);
    rd_entry = RW_MASK[tid_q] ? mem_rw[rd_base +: N_DATA_BITS] : mem_ro[rd_base +: N_DATA_BITS];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      stat_q   <= ST_OK;
      op_q     <= '0;
      addr_q   <= '0;
      tid_q    <= '0;
      fill_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (cmd_hit) begin
          op_q     <= cmnd_op;
          addr_q   <= cmnd_addr;
          tid_q    <= cmnd_table_id;
          fill_cnt <= '0;
          if (cmd_err != ST_OK) begin
            stat_q <= cmd_err;
          end else if (cmnd_op == OP_NOP) begin
            stat_q <= ST_OK;
          end else begin
            stat_q <= ST_BUSY;
            state  <= (cmnd_op == OP_INIT) ? S_FILL : S_EXEC;
          end
        end
        S_EXEC: begin
          state  <= S_IDLE;
          stat_q <= ST_OK;
        end
        S_FILL: begin
          fill_cnt <= fill_cnt + AW'(1);
          if (fill_cnt == AW'(N_ENTRIES - 1)) begin
            fill_cnt <= '0;
            state    <= S_IDLE;
            stat_q   <= ST_OK;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Status address/table latch for every accepted command, errors included.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_addr     <= '0;
      stat_table_id <= '0;
    end else if (cmd_hit) begin
      stat_addr     <= cmnd_addr;
      stat_table_id <= cmnd_table_id;
    end
  end

  // A completing read overrides a host data write landing in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      data_reg <= '0;
    else if (rd_done)
      data_reg <= rd_entry;
    else if (wr_stb && reg_addr == DATA_ADDRESS)
      data_reg <= wr_dat;
  end

  assign stat_code = stat_q;
  assign rd_dat    = data_reg;

  for (genvar t = 0; t < N_TABLES; t++) begin : g_tbl
    if (RW_MASK[t]) begin : g_rw
      logic sel;
      assign sel = (tid_q == TW'(t));
      nx_rwreg_ia_bank #(
        .N_ENTRIES   (N_ENTRIES),
        .N_DATA_BITS (N_DATA_BITS)
      ) u_bank (
        .clk   (clk),
        .rst   (rst),
        .we    (sel && ((state == S_EXEC && op_q == OP_WRITE) || state == S_FILL)),
        .waddr ((state == S_FILL) ? fill_cnt : addr_q),
        .wdat  (data_reg),
        .clr   (sel && CLR_EN && state == S_EXEC && op_q == OP_READ_CLR),
        .rdata (mem_rw[t*TBL_BITS +: TBL_BITS])
      );
    end else begin : g_ro
      assign mem_rw[t*TBL_BITS +: TBL_BITS] = '0;
    end
  end

endmodule
